// File: rtl/cnu_pkg.sv
// Shared constants for the check-node unit datapath.
// Build option: RCA_OVF_STICKY_EN enables the sticky carry flag in ripple_carry_adder.
package cnu_pkg;

  localparam int CNU_ADD_WIDTH = 5;

endpackage

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the CNU ripple-carry adder.
// Build option: RCA_OVF_STICKY_EN only changes how ovf_sticky is driven.
interface ripple_carry_adder_if
  import cnu_pkg::*;
#(
  parameter int WIDTH = CNU_ADD_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic [WIDTH-1:0] SUM_Q;
  logic             COUT_Q;
  logic             OVF_STICKY;

  modport master (
    output A,
    output B,
    input  SUM,
    input  COUT,
    input  SUM_Q,
    input  COUT_Q,
    input  OVF_STICKY
  );

  modport slave (
    input  A,
    input  B,
    output SUM,
    output COUT,
    output SUM_Q,
    output COUT_Q,
    output OVF_STICKY
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell, chained to form the ripple-carry adder.
// Build option: RCA_OVF_STICKY_EN has no effect on this cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // Propagate term shared by sum and carry.
  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder with a registered result copy.
// Build option: define RCA_OVF_STICKY_EN to make OVF_STICKY a sticky carry flag.
module ripple_carry_adder
  import cnu_pkg::*;
#(
  parameter int WIDTH = CNU_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic [WIDTH-1:0] SUM_Q,
  output logic             COUT_Q,
  output logic             OVF_STICKY
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .sum  (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign SUM  = sum_d;
  assign COUT = c[WIDTH];

`ifdef RCA_OVF_STICKY_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = ovf_q | c[WIDTH];
`endif

  // Capture the combinational result every edge; reset clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef RCA_OVF_STICKY_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_d;
      cout_q <= c[WIDTH];
`ifdef RCA_OVF_STICKY_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign SUM_Q  = sum_q;
  assign COUT_Q = cout_q;

`ifdef RCA_OVF_STICKY_EN
  assign OVF_STICKY = ovf_q;
`else
  assign OVF_STICKY = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed + random bench for ripple_carry_adder (WIDTH=5 and WIDTH=1).
// Build option: RCA_OVF_STICKY_EN selects the expected sticky-flag behaviour.
module tb_ripple_carry_adder;

  localparam int W = 5;
`ifdef RCA_OVF_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ripple_carry_adder_if #(.WIDTH(W)) bus ();

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (bus.A),
    .B          (bus.B),
    .SUM        (bus.SUM),
    .COUT       (bus.COUT),
    .SUM_Q      (bus.SUM_Q),
    .COUT_Q     (bus.COUT_Q),
    .OVF_STICKY (bus.OVF_STICKY)
  );

  logic a1, b1, s1, c1, sq1, cq1, ov1;

  ripple_carry_adder #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a1),
    .B          (b1),
    .SUM        (s1),
    .COUT       (c1),
    .SUM_Q      (sq1),
    .COUT_Q     (cq1),
    .OVF_STICKY (ov1)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on whatever A/B are at each edge.
  int m_sq;
  int m_cq;
  int m_ov;

  always @(posedge clk or negedge rst_n) begin
    int t;
    if (!rst_n) begin
      m_sq = 0;
      m_cq = 0;
      m_ov = 0;
    end else begin
      t = int'(bus.A) + int'(bus.B);
      m_sq = t % (1 << W);
      m_cq = t / (1 << W);
      if (STK_EN && m_cq != 0) m_ov = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int a, input int b);
    int t;
    @(negedge clk);
    bus.A = W'(a);
    bus.B = W'(b);
    t = a + b;
    #1;
    chk("sum", 32'(bus.SUM), 32'(t % 32));
    chk("cout", 32'(bus.COUT), 32'(t / 32));
    @(posedge clk);
    #1;
    chk("sum_q", 32'(bus.SUM_Q), 32'(m_sq));
    chk("cout_q", 32'(bus.COUT_Q), 32'(m_cq));
    chk("ovf", 32'(bus.OVF_STICKY), 32'(m_ov));
  endtask

  initial begin
    bus.A = '0;
    bus.B = '0;
    a1 = 1'b0;
    b1 = 1'b0;

    #1;
    chk("rst_sum_q", 32'(bus.SUM_Q), 32'd0);
    chk("rst_cout_q", 32'(bus.COUT_Q), 32'd0);
    chk("rst_ovf", 32'(bus.OVF_STICKY), 32'd0);
    chk("zero_sum", 32'(bus.SUM), 32'd0);
    chk("zero_cout", 32'(bus.COUT), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(3, 4);
    chk("d34_sum_q", 32'(bus.SUM_Q), 32'd7);
    chk("d34_cout_q", 32'(bus.COUT_Q), 32'd0);
    chk("d34_ovf", 32'(bus.OVF_STICKY), 32'd0);

    step(31, 31);
    chk("max_sum", 32'(bus.SUM), 32'd30);
    chk("max_cout", 32'(bus.COUT), 32'd1);

    step(0, 0);
    chk("stk_hold", 32'(bus.OVF_STICKY), 32'(STK_EN));
    step(5, 9);
    chk("stk_hold2", 32'(bus.OVF_STICKY), 32'(STK_EN));

    for (int i = 0; i < 50; i++) begin
      step(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
      chk("rand_inv", 32'(bus.SUM) + 32'(bus.COUT) * 32,
          32'(bus.A) + 32'(bus.B));
    end

    step(31, 1);
    chk("wrap_sum", 32'(bus.SUM), 32'd0);
    chk("wrap_cout", 32'(bus.COUT), 32'd1);
    chk("wrap_ovf", 32'(bus.OVF_STICKY), 32'(STK_EN));

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum_q", 32'(bus.SUM_Q), 32'd0);
    chk("mid_rst_cout_q", 32'(bus.COUT_Q), 32'd0);
    chk("mid_rst_ovf", 32'(bus.OVF_STICKY), 32'd0);
    chk("mid_rst_sum", 32'(bus.SUM), 32'd0);
    chk("mid_rst_cout", 32'(bus.COUT), 32'd1);
    rst_n = 1'b1;

    step(2, 2);
    chk("post_rst_ovf", 32'(bus.OVF_STICKY), 32'd0);
    chk("post_rst_sum_q", 32'(bus.SUM_Q), 32'd4);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = i[0];
      b1 = i[1];
      #1;
      chk("w1_sum", 32'(s1), 32'((i[0] + i[1]) % 2));
      chk("w1_cout", 32'(c1), 32'((i[0] + i[1]) / 2));
      @(posedge clk);
      #1;
      chk("w1_sum_q", 32'(sq1), 32'((i[0] + i[1]) % 2));
      chk("w1_cout_q", 32'(cq1), 32'((i[0] + i[1]) / 2));
    end

    if (miscompares == 0) $display("All tests passed.");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
